// File: rtl/reg_ctx_engine.sv
// Context save/restore sequencer for the register file.
//
// Walks slot 0 (return-address register) and general registers 1..2^REGBITS-1.
// A save reads each register through the synchronous read port and writes it to
// memory at base_addr+idx. A restore reads memory at base_addr+idx and writes
// the word back through the register file (or RA) write port.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, dir, base_addr request; dir 0 = save, 1 = restore (sampled in IDLE)
//   busy, done            busy while sequencing; done pulses for one cycle
//   rf_rd_addr            register file read select (data returns next cycle)
//   rf_rd_data, ra_rd_data register / RA read data
//   rf_wr_*, ra_wr_*      register file / RA write port
//   mem_*                 memory request/ack interface (word addressed)
module reg_ctx_engine #(
  parameter int unsigned REGBITS = 5,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDRW   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic [ADDRW-1:0]   base_addr,
  output logic               busy,
  output logic               done,
  output logic [REGBITS-1:0] rf_rd_addr,
  input  logic [WIDTH-1:0]   rf_rd_data,
  input  logic [WIDTH-1:0]   ra_rd_data,
  output logic               rf_wr_en,
  output logic [REGBITS-1:0] rf_wr_addr,
  output logic [WIDTH-1:0]   rf_wr_data,
  output logic               ra_wr_en,
  output logic [WIDTH-1:0]   ra_wr_data,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDRW-1:0]   mem_addr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ack
);

  typedef enum logic [2:0] {
    StIdle,
    StSvRd,
    StSvWait,
    StSvMem,
    StRsMem,
    StRsWr,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [REGBITS-1:0] idx_q, idx_d;
  logic [ADDRW-1:0]   base_q, base_d;
  logic [WIDTH-1:0]   hold_q, hold_d;

  logic [ADDRW-1:0]   frame_addr;
  logic               idx_last;

  // Address wraps modulo 2^ADDRW by construction of the adder width.
  assign frame_addr = base_q + ADDRW'(idx_q);
  assign idx_last   = &idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      base_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    base_d     = base_q;
    hold_d     = hold_q;
    busy       = 1'b0;
    done       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_rd_addr = '0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_data = '0;
    ra_wr_en   = 1'b0;
    ra_wr_data = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          idx_d   = '0;
          base_d  = base_addr;
          state_d = dir ? StRsMem : StSvRd;
        end
      end
      StSvRd: begin
        busy       = 1'b1;
        rf_rd_addr = idx_q;
        state_d    = StSvWait;
      end
      StSvWait: begin
        busy    = 1'b1;
        // Slot 0 carries RA instead of R0.
        hold_d  = (idx_q == '0) ? ra_rd_data : rf_rd_data;
        state_d = StSvMem;
      end
      StSvMem: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = frame_addr;
        mem_wdata = hold_q;
        if (mem_ack) begin
          if (idx_last) begin
            state_d = StDone;
          end else begin
            idx_d   = idx_q + REGBITS'(1);
            state_d = StSvRd;
          end
        end
      end
      StRsMem: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = 1'b0;
        mem_addr = frame_addr;
        if (mem_ack) begin
          hold_d  = mem_rdata;
          state_d = StRsWr;
        end
      end
      StRsWr: begin
        busy = 1'b1;
        if (idx_q == '0) begin
          ra_wr_en   = 1'b1;
          ra_wr_data = hold_q;
        end else begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = idx_q;
          rf_wr_data = hold_q;
        end
        if (idx_last) begin
          state_d = StDone;
        end else begin
          idx_d   = idx_q + REGBITS'(1);
          state_d = StRsMem;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are forced low during reset so an interrupted operation cannot
    // issue a write strobe or memory request in the reset cycle.
    if (reset) begin
      busy       = 1'b0;
      done       = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      rf_rd_addr = '0;
      rf_wr_en   = 1'b0;
      rf_wr_addr = '0;
      rf_wr_data = '0;
      ra_wr_en   = 1'b0;
      ra_wr_data = '0;
    end
  end

endmodule

// File: tb/tb_reg_ctx_engine.sv
module tb_reg_ctx_engine;

  localparam int REGBITS = 5;
  localparam int WIDTH   = 32;
  localparam int ADDRW   = 16;
  localparam int NREG    = 32;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               dir = 1'b0;
  logic [ADDRW-1:0]   base_addr = '0;
  logic               busy, done;
  logic [REGBITS-1:0] rf_rd_addr;
  logic [WIDTH-1:0]   rf_rd_data, ra_rd_data;
  logic               rf_wr_en, ra_wr_en;
  logic [REGBITS-1:0] rf_wr_addr;
  logic [WIDTH-1:0]   rf_wr_data, ra_wr_data;
  logic               mem_req, mem_we, mem_ack;
  logic [ADDRW-1:0]   mem_addr;
  logic [WIDTH-1:0]   mem_wdata, mem_rdata;

  reg_ctx_engine #(
    .REGBITS(REGBITS),
    .WIDTH  (WIDTH),
    .ADDRW  (ADDRW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dir       (dir),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data),
    .ra_rd_data(ra_rd_data),
    .rf_wr_en  (rf_wr_en),
    .rf_wr_addr(rf_wr_addr),
    .rf_wr_data(rf_wr_data),
    .ra_wr_en  (ra_wr_en),
    .ra_wr_data(ra_wr_data),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  // ---------------- models ----------------
  logic [WIDTH-1:0] regs [0:NREG-1];
  logic [WIDTH-1:0] ra_reg;
  logic [WIDTH-1:0] mem [0:65535];
  logic [WIDTH-1:0] rd_q, ra_q;
  int               ack_delay = 0;
  int               wait_cnt = 0;
  logic             stray_ack = 1'b0;

  always @(posedge clk) begin
    rd_q <= regs[rf_rd_addr];
    ra_q <= ra_reg;
    if (rf_wr_en) regs[rf_wr_addr] <= rf_wr_data;
    if (ra_wr_en) ra_reg <= ra_wr_data;
    if (mem_req && mem_we && mem_ack) mem[mem_addr] <= mem_wdata;
    if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end

  assign rf_rd_data = rd_q;
  assign ra_rd_data = ra_q;
  assign mem_rdata  = mem[mem_addr];
  assign mem_ack    = stray_ack | (mem_req & (wait_cnt >= ack_delay));

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    n_chk++;
    $display("FAIL %s: event not expected / not reached", name);
  endtask

  typedef struct packed {
    logic             ra;
    logic [ADDRW-1:0] addr;
    logic [WIDTH-1:0] data;
  } exp_t;

  exp_t exp_mem_q[$];
  exp_t exp_reg_q[$];

  int wack_cnt = 0;
  int wr_cnt = 0;
  int rf0_cnt = 0;

  logic             prev_req = 1'b0, prev_ack = 1'b0, prev_we = 1'b0;
  logic [ADDRW-1:0] prev_addr = '0;
  logic [WIDTH-1:0] prev_wdata = '0;

  // Monitor: pops the scoreboard whenever the DUT commits a write.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (mem_req && mem_we && mem_ack) begin
        wack_cnt++;
        if (exp_mem_q.size() == 0) fail("mem_write_unexpected");
        else begin
          e = exp_mem_q.pop_front();
          chk("mem_write_addr", 128'(mem_addr), 128'(e.addr));
          chk("mem_write_data", 128'(mem_wdata), 128'(e.data));
        end
      end
      if (rf_wr_en || ra_wr_en) wr_cnt++;
      if (rf_wr_en && rf_wr_addr == '0) rf0_cnt++;
      if (ra_wr_en) begin
        if (exp_reg_q.size() == 0) fail("ra_write_unexpected");
        else begin
          e = exp_reg_q.pop_front();
          chk("ra_write_slot", 128'({1'b1, 16'h0}), 128'({e.ra, e.addr}));
          chk("ra_write_data", 128'(ra_wr_data), 128'(e.data));
        end
      end
      if (rf_wr_en) begin
        if (exp_reg_q.size() == 0) fail("rf_write_unexpected");
        else begin
          e = exp_reg_q.pop_front();
          chk("rf_write_addr", 128'({1'b0, 11'h0, rf_wr_addr}), 128'({e.ra, e.addr}));
          chk("rf_write_data", 128'(rf_wr_data), 128'(e.data));
        end
      end
      if (prev_req && !prev_ack && mem_req)
        chk("mem_hold_stable", 128'({mem_we, mem_addr, mem_wdata}),
            128'({prev_we, prev_addr, prev_wdata}));
    end
    prev_req   = mem_req && !reset;
    prev_ack   = mem_ack;
    prev_we    = mem_we;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
  end

  function automatic logic [127:0] all_outs();
    return {busy, done, mem_req, mem_we, mem_addr, mem_wdata, rf_rd_addr,
            rf_wr_en, rf_wr_addr, rf_wr_data, ra_wr_en, ra_wr_data};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic init_regs();
    for (int i = 0; i < NREG; i++) regs[i] = 32'hA000_0000 + i;
    ra_reg = 32'h0000_1234;
  endtask

  task automatic push_save(input logic [ADDRW-1:0] base);
    exp_t e;
    for (int i = 0; i < NREG; i++) begin
      e.ra   = 1'b0;
      e.addr = base + ADDRW'(i);
      e.data = (i == 0) ? 32'h0000_1234 : 32'hA000_0000 + i;
      exp_mem_q.push_back(e);
    end
  endtask

  task automatic push_restore(input logic [WIDTH-1:0] pat, input int upto);
    exp_t e;
    for (int i = 0; i < upto; i++) begin
      e.ra   = (i == 0);
      e.addr = 16'(i);
      e.data = pat + i;
      exp_reg_q.push_back(e);
    end
  endtask

  task automatic run_op(input logic d, input logic [ADDRW-1:0] base, input int exp_lat,
                        input string nm, input bit repulse, input bit stray);
    int n;
    bit got;
    @(negedge clk);
    start = 1'b1;
    dir = d;
    base_addr = base;
    @(posedge clk);
    n = 0;
    got = 0;
    while (n < 3000 && !got) begin
      @(negedge clk);
      n++;
      start = 1'b0;
      dir = !d;
      base_addr = 16'hDEAD;
      if (n == 1) chk({nm, "_busy_after_start"}, 128'(busy), 128'(1));
      if (repulse && (n == 5 || n == 40)) start = 1'b1;
      stray_ack = stray && !mem_req && busy && n >= 10 && n <= 30;
      if (done) got = 1;
    end
    stray_ack = 1'b0;
    start = 1'b0;
    if (!got) fail({nm, "_done_timeout"});
    else begin
      chk({nm, "_latency"}, 128'(n), 128'(exp_lat));
      chk({nm, "_busy_in_done"}, 128'(busy), 128'(0));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk({nm, "_idle_after_done"}, 128'({busy, done}), 128'(0));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int w0, a0, bail;
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    init_regs();

    // Reset state
    repeat (3) @(negedge clk);
    chk("outputs_in_reset", all_outs(), '0);
    reset = 1'b0;
    @(negedge clk);
    chk("outputs_after_reset", all_outs(), '0);

    // 1: save, zero-wait
    w0 = wr_cnt;
    push_save(16'h0100);
    run_op(1'b0, 16'h0100, 97, "save0", 0, 0);
    chk("save0_queue_empty", 128'(exp_mem_q.size()), 128'(0));
    chk("save0_no_wr_strobe", 128'(wr_cnt - w0), 128'(0));
    chk("save0_mem_0100", 128'(mem[16'h0100]), 128'(32'h0000_1234));
    chk("save0_mem_011F", 128'(mem[16'h011F]), 128'(32'hA000_001F));

    // 2: restore, zero-wait
    for (int i = 0; i < NREG; i++) mem[16'h0200 + i] = 32'h5000_0000 + i;
    a0 = rf0_cnt;
    push_restore(32'h5000_0000, NREG);
    run_op(1'b1, 16'h0200, 65, "rest0", 0, 0);
    chk("rest0_queue_empty", 128'(exp_reg_q.size()), 128'(0));
    chk("rest0_no_r0_write", 128'(rf0_cnt - a0), 128'(0));
    chk("rest0_ra", 128'(ra_reg), 128'(32'h5000_0000));
    chk("rest0_r31", 128'(regs[31]), 128'(32'h5000_001F));

    // 3: save with 3 wait states per request
    init_regs();
    for (int i = 0; i < NREG; i++) mem[16'h0100 + i] = '0;
    ack_delay = 3;
    a0 = wack_cnt;
    w0 = wr_cnt;
    push_save(16'h0100);
    run_op(1'b0, 16'h0100, 193, "save_wait", 0, 0);
    ack_delay = 0;
    chk("save_wait_queue_empty", 128'(exp_mem_q.size()), 128'(0));
    chk("save_wait_ack_count", 128'(wack_cnt - a0), 128'(32));
    chk("save_wait_no_wr_strobe", 128'(wr_cnt - w0), 128'(0));
    chk("save_wait_mem_0110", 128'(mem[16'h0110]), 128'(32'hA000_0010));

    // 4: address wrap
    push_save(16'hFFF0);
    run_op(1'b0, 16'hFFF0, 97, "save_wrap", 0, 0);
    chk("wrap_queue_empty", 128'(exp_mem_q.size()), 128'(0));
    chk("wrap_mem_FFF0", 128'(mem[16'hFFF0]), 128'(32'h0000_1234));
    chk("wrap_mem_FFFF", 128'(mem[16'hFFFF]), 128'(32'hA000_000F));
    chk("wrap_mem_000F", 128'(mem[16'h000F]), 128'(32'hA000_001F));

    // 5: re-start while busy plus stray acks
    a0 = wack_cnt;
    push_save(16'h0100);
    run_op(1'b0, 16'h0100, 97, "save_noise", 1, 1);
    chk("noise_queue_empty", 128'(exp_mem_q.size()), 128'(0));
    chk("noise_ack_count", 128'(wack_cnt - a0), 128'(32));
    chk("noise_mem_0105", 128'(mem[16'h0105]), 128'(32'hA000_0005));

    // 6: reset during restore at idx 10, then a clean restore
    init_regs();
    for (int i = 0; i < NREG; i++) mem[16'h0300 + i] = 32'h7000_0000 + i;
    push_restore(32'h7000_0000, 10);
    @(negedge clk);
    start = 1'b1;
    dir = 1'b1;
    base_addr = 16'h0300;
    @(posedge clk);
    bail = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      bail++;
    end while (!(mem_req && mem_addr == 16'h030A) && bail < 200);
    if (bail >= 200) fail("reset_idx10_not_reached");
    reset = 1'b1;
    #1;
    chk("outputs_in_midop_reset", all_outs(), '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("outputs_after_midop_reset", all_outs(), '0);
    chk("reset_queue_empty", 128'(exp_reg_q.size()), 128'(0));
    chk("reset_r9_written", 128'(regs[9]), 128'(32'h7000_0009));
    for (int i = 10; i < NREG; i++)
      chk("reset_reg_untouched", 128'(regs[i]), 128'(32'hA000_0000 + i));
    push_restore(32'h7000_0000, NREG);
    run_op(1'b1, 16'h0300, 65, "rest_after_reset", 0, 0);
    chk("rest2_queue_empty", 128'(exp_reg_q.size()), 128'(0));
    chk("rest2_r20", 128'(regs[20]), 128'(32'h7000_0014));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
